// File: rtl/bit_grouper_if.sv
// Byte-in / symbol-out bus bundle for bit_grouper: upstream byte write port
// (DAT_I/CYC_I/STB_I/WE_I/ACK_O) and downstream symbol port (DAT_O/CYC_O/STB_O/WE_O/ACK_I).
interface bit_grouper_if;
  logic [7:0] DAT_I;
  logic       CYC_I;
  logic       STB_I;
  logic       WE_I;
  logic       ACK_O;
  logic [5:0] DAT_O;
  logic       CYC_O;
  logic       STB_O;
  logic       WE_O;
  logic       ACK_I;

  // master: the environment (byte source and symbol sink); slave: the grouper
  modport master (
    output DAT_I, CYC_I, STB_I, WE_I, ACK_I,
    input  ACK_O, DAT_O, CYC_O, STB_O, WE_O
  );

  modport slave (
    input  DAT_I, CYC_I, STB_I, WE_I, ACK_I,
    output ACK_O, DAT_O, CYC_O, STB_O, WE_O
  );
endinterface

// File: rtl/bit_grouper.sv
// Regroups an LSB-first byte stream into 1/2/4/6-bit modulation symbols.
// Define FLUSH_PAD_EN to emit a zero-padded final symbol for residual bits at frame end.
module bit_grouper (
  input  logic           CLK_I,
  input  logic           RST_I,
  input  logic [1:0]     MOD,
  bit_grouper_if.slave   bus
);

  typedef enum logic [1:0] {
    MOD_QPSK  = 2'b00,
    MOD_BPSK  = 2'b01,
    MOD_QAM16 = 2'b10,
    MOD_QAM64 = 2'b11
  } mod_e;

  mod_e        mod_r;
  logic        icyc;
  logic [13:0] bit_buf;
  logic [3:0]  cnt;
  logic [5:0]  dat_r;
  logic        stb_r;
  logic        cyc_r;

  logic [3:0]  bps;
  logic        cyc_rise;
  logic        accept;
  logic        load;
  logic        residual;
  logic        flush_emit;
  logic        residual_clr;
  logic [5:0]  load_sym;
  logic [5:0]  flush_sym;

  always_comb begin
    bps = 4'd2;
    case (mod_r)
      MOD_QAM64: bps = 4'd6;
      MOD_QAM16: bps = 4'd4;
      MOD_BPSK:  bps = 4'd1;
      default:   bps = 4'd2;
    endcase
  end

  assign cyc_rise = bus.CYC_I & ~icyc;

  // Accept only while the buffer cannot yet form a symbol, so a byte write and
  // a symbol load never touch the buffer in the same cycle.
  assign accept   = bus.CYC_I & bus.STB_I & bus.WE_I & (cnt < bps) & ~RST_I;
  assign load     = (cnt >= bps) & (~stb_r | bus.ACK_I);
  assign residual = ~bus.CYC_I & (cnt != 4'd0) & (cnt < bps);
  assign load_sym = bit_buf[5:0] & ~(6'h3F << bps);

`ifdef FLUSH_PAD_EN
  assign flush_emit   = residual & (~stb_r | bus.ACK_I);
  assign residual_clr = flush_emit;
  assign flush_sym    = bit_buf[5:0] & ~(6'h3F << cnt);
`else
  assign flush_emit   = 1'b0;
  assign residual_clr = residual;
  assign flush_sym    = 6'd0;
`endif

  assign bus.ACK_O = accept;
  assign bus.DAT_O = dat_r;
  assign bus.STB_O = stb_r;
  assign bus.WE_O  = stb_r;
  assign bus.CYC_O = cyc_r;

  always_ff @(posedge CLK_I) begin
    // NOTE: the reset is synchronous, and every register including the bit
    // buffer is cleared so that a mid-frame reset leaves no stale bits behind.
    if (RST_I) begin
      mod_r   <= MOD_QPSK;
      icyc    <= 1'b0;
      bit_buf <= '0;
      cnt     <= '0;
      dat_r   <= '0;
      stb_r   <= 1'b0;
      cyc_r   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every branch sees the pre-edge
      // values of bit_buf/cnt/stb_r regardless of statement order.
      icyc <= bus.CYC_I;
      if (cyc_rise) mod_r <= mod_e'(MOD);

      if (accept) begin
        bit_buf <= (bit_buf & ~(14'hFF << cnt)) | (14'(bus.DAT_I) << cnt);
        cnt     <= cnt + 4'd8;
      end else if (load) begin
        bit_buf <= bit_buf >> bps;
        cnt     <= cnt - bps;
      end else if (residual_clr) begin
        bit_buf <= '0;
        cnt     <= '0;
      end

      if (load) begin
        dat_r <= load_sym;
        stb_r <= 1'b1;
      end else if (flush_emit) begin
        dat_r <= flush_sym;
        stb_r <= 1'b1;
      end else if (stb_r & bus.ACK_I) begin
        stb_r <= 1'b0;
      end

      // Downstream cycle ends only once the buffer is empty and the last symbol is taken
      if (cyc_rise) begin
        cyc_r <= 1'b1;
      end else if (~bus.CYC_I & (cnt == 4'd0) & (~stb_r | bus.ACK_I)) begin
        cyc_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bit_grouper.sv
// Directed bench for bit_grouper: an LSB-first bit-queue model feeds an expected-symbol
// scoreboard that a negedge monitor drains on every downstream transfer.
module tb_bit_grouper;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mod;

  bit_grouper_if bus ();

  bit_grouper dut (
    .CLK_I (clk),
    .RST_I (rst),
    .MOD   (mod),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [5:0] exp_q[$];
  logic       model_bits[$];
  int         frame_bps = 2;
  int         w;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int bps_of(input logic [1:0] m);
    case (m)
      2'b11:   return 6;
      2'b10:   return 4;
      2'b00:   return 2;
      default: return 1;
    endcase
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [5:0] sym;
    for (int i = 0; i < 8; i++) model_bits.push_back(b[i]);
    while (model_bits.size() >= frame_bps) begin
      sym = '0;
      for (int j = 0; j < frame_bps; j++) sym[j] = model_bits.pop_front();
      exp_q.push_back(sym);
    end
  endtask

  task automatic model_flush();
`ifdef FLUSH_PAD_EN
    logic [5:0] sym;
    int         n;
    n = model_bits.size();
    if (n > 0) begin
      sym = '0;
      for (int j = 0; j < n; j++) sym[j] = model_bits.pop_front();
      exp_q.push_back(sym);
    end
`endif
    model_bits.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int waited);
    bus.DAT_I = b;
    bus.STB_I = 1'b1;
    bus.WE_I  = 1'b1;
    waited    = 0;
    @(negedge clk);
    while (!bus.ACK_O && waited < 64) begin
      waited++;
      @(negedge clk);
    end
    check("ack_within_bound", 8'(bus.ACK_O), 8'd1);
    model_byte(b);
    @(posedge clk);
    #1;
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
  endtask

  task automatic start_frame(input logic [1:0] m);
    mod       = m;
    frame_bps = bps_of(m);
    bus.CYC_I = 1'b1;
    tick();
    check("cyc_o_rise", 8'(bus.CYC_O), 8'd1);
  endtask

  task automatic end_frame();
    int n;
    bus.CYC_I = 1'b0;
    model_flush();
    n = 0;
    @(negedge clk);
    while (bus.CYC_O && n < 64) begin
      n++;
      @(negedge clk);
    end
    check("cyc_o_fall", 8'(bus.CYC_O), 8'd0);
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    tick();
  endtask

  // Scoreboard side: a symbol transfers at the next edge when STB_O & ACK_I
  always @(negedge clk) begin
    if (!rst && bus.STB_O && bus.ACK_I) begin
      check("symbol_expected", 8'(exp_q.size() != 0), 8'd1);
      if (exp_q.size() != 0) check("symbol_value", 8'(bus.DAT_O), 8'(exp_q.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    mod       = 2'b00;
    bus.DAT_I = 8'h00;
    bus.CYC_I = 1'b1;
    bus.STB_I = 1'b1;
    bus.WE_I  = 1'b1;
    bus.ACK_I = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stb_o", 8'(bus.STB_O), 8'd0);
    check("reset_cyc_o", 8'(bus.CYC_O), 8'd0);
    check("reset_dat_o", 8'(bus.DAT_O), 8'd0);
    check("reset_we_o",  8'(bus.WE_O),  8'd0);
    check("reset_ack_o", 8'(bus.ACK_O), 8'd0);
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
    rst       = 1'b0;
    tick();

    // QAM16 0xA5, with a MOD change mid-frame that must be ignored
    start_frame(2'b10);
    mod = 2'b01;
    send_byte(8'hA5, w);
    check("qam16_wait", 8'(w), 8'd0);
    check("qam16_latency_stb", 8'(bus.STB_O), 8'd0);
    tick();
    check("qam16_stb_1", 8'(bus.STB_O), 8'd1);
    check("qam16_sym_1", 8'(bus.DAT_O), 8'h05);
    check("qam16_we_1",  8'(bus.WE_O),  8'd1);
    tick();
    check("qam16_stb_2", 8'(bus.STB_O), 8'd1);
    check("qam16_sym_2", 8'(bus.DAT_O), 8'h0A);
    tick();
    check("qam16_stb_idle", 8'(bus.STB_O), 8'd0);
    check("qam16_we_idle",  8'(bus.WE_O),  8'd0);
    end_frame();

    // QAM64 0x41 0x10 0x04: ACK_O held off one cycle each time cnt >= 6
    start_frame(2'b11);
    send_byte(8'h41, w);
    check("qam64_wait_0", 8'(w), 8'd0);
    send_byte(8'h10, w);
    check("qam64_wait_1", 8'(w), 8'd1);
    send_byte(8'h04, w);
    check("qam64_wait_2", 8'(w), 8'd1);
    end_frame();

    // BPSK 0x96: next byte waits for all eight symbols to load
    start_frame(2'b01);
    send_byte(8'h96, w);
    check("bpsk_wait_0", 8'(w), 8'd0);
    send_byte(8'h00, w);
    check("bpsk_wait_1", 8'(w), 8'd8);
    end_frame();

    // QAM64 residual at frame end: 0x3F then (with padding) 0x03
    start_frame(2'b11);
    send_byte(8'hFF, w);
    end_frame();

    // QPSK 0xE4 under five cycles of backpressure
    start_frame(2'b00);
    bus.ACK_I = 1'b0;
    send_byte(8'hE4, w);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_stb_hold", 8'(bus.STB_O), 8'd1);
      check("bp_dat_hold", 8'(bus.DAT_O), 8'h00);
      tick();
    end
    bus.ACK_I = 1'b1;
    end_frame();

    // Reset while cnt = 4 with a symbol pending: everything discarded
    start_frame(2'b10);
    bus.ACK_I = 1'b0;
    send_byte(8'h3C, w);
    tick();
    check("rst_pre_stb", 8'(bus.STB_O), 8'd1);
    check("rst_pre_dat", 8'(bus.DAT_O), 8'h0C);
    rst = 1'b1;
    tick();
    check("rst_mid_stb_o", 8'(bus.STB_O), 8'd0);
    check("rst_mid_cyc_o", 8'(bus.CYC_O), 8'd0);
    check("rst_mid_dat_o", 8'(bus.DAT_O), 8'd0);
    exp_q.delete();
    model_bits.delete();
    bus.CYC_I = 1'b0;
    bus.ACK_I = 1'b1;
    rst       = 1'b0;
    repeat (6) tick();
    check("rst_no_flush_stb", 8'(bus.STB_O), 8'd0);
    check("rst_no_flush_cyc", 8'(bus.CYC_O), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
